// File: rtl/spark_tester_pkg.sv
// spark_tester_pkg: register map, IDs and CRC-32 helpers shared by the tester core
package spark_tester_pkg;
  localparam logic [31:0] IP_ID = 32'h5350_4B01;
  localparam int BUF_WORDS = 32;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
  localparam logic [3:0] BLK_GEN = 4'h0, BLK_ANA = 4'h1, BLK_MUX = 4'h2;
  localparam logic [7:0] OFF_ID = 8'h00, OFF_SEL = 8'h08, OFF_FLIP = 8'h0C, OFF_CTRL = 8'h10,
                         OFF_IFG = 8'h14, OFF_FSIZE = 8'h44, OFF_DATA = 8'h50,
                         OFF_PKTS = 8'h20, OFF_OCTETS = 8'h28, OFF_IDLE = 8'h30,
                         OFF_BAD_PKTS = 8'h58, OFF_BAD_OCT = 8'h60;
  typedef enum logic [2:0] {GEN_IDLE, GEN_PRE, GEN_FRAME, GEN_FCS, GEN_GAP} gen_state_e;
  typedef enum logic [2:0] {CNT_PKTS, CNT_OCTETS, CNT_IDLE, CNT_BAD_PKTS, CNT_BAD_OCT, CNT_NONE} cnt_sel_e;
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'd0, d};
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ CRC_POLY : c >> 1;
    return c;
  endfunction
  // Both words of a 64-bit counter share off[7:3]; off[2] picks high (0) or low (1)
  function automatic cnt_sel_e cnt_decode(input logic [7:0] off);
    return off[7:3] == OFF_PKTS[7:3] ? CNT_PKTS :
           off[7:3] == OFF_OCTETS[7:3] ? CNT_OCTETS :
           off[7:3] == OFF_IDLE[7:3] ? CNT_IDLE :
           off[7:3] == OFF_BAD_PKTS[7:3] ? CNT_BAD_PKTS :
           off[7:3] == OFF_BAD_OCT[7:3] ? CNT_BAD_OCT : CNT_NONE;
  endfunction
endpackage

// File: rtl/spark_port_tester_if.sv
// spark_port_tester_if: single-outstanding register bus between interconnect and tester
interface spark_port_tester_if;
  logic reg_req;
  logic reg_we;
  logic [11:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;
  logic reg_ack;
  modport master(output reg_req, reg_we, reg_addr, reg_wdata, input reg_rdata, reg_ack);
  modport slave(input reg_req, reg_we, reg_addr, reg_wdata, output reg_rdata, reg_ack);
endinterface

// File: rtl/spark_crc32_byte.sv
// spark_crc32_byte: one-byte update of the reflected IEEE CRC-32 register
module spark_crc32_byte
  import spark_tester_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);
  assign crc_next = crc32_byte(crc, data);
endmodule

// File: rtl/spark_port_tester.sv
// spark_port_tester: GMII frame generator, analyzer and port mux behind a register bus
module spark_port_tester
  import spark_tester_pkg::*;
(
  input  logic aclk,
  input  logic arstn,
  spark_port_tester_if.slave bus,
  output logic [7:0] gmii0_txd,
  output logic       gmii0_tx_en,
  output logic [7:0] gmii1_txd,
  output logic       gmii1_tx_en,
  input  logic [7:0] gmii0_rxd,
  input  logic       gmii0_rx_dv,
  input  logic [7:0] gmii1_rxd,
  input  logic       gmii1_rx_dv
);
  localparam int AW = $clog2(BUF_WORDS);
  logic [31:0] gen_flip, ana_flip, gen_ifg, gen_fsize, shadow, rd_val;
  logic [1:0] gen_ctrl, ana_ctrl;
  logic [2:0] sel;
  logic [31:0] buf_mem [BUF_WORDS];
  logic [AW:0] wr_ptr;
  logic [63:0] ctr [5];
  logic sh_vld, wr, rd, hi;
  cnt_sel_e sh_idx, ci;
  logic [3:0] blk;
  logic [7:0] off;
  assign blk = bus.reg_addr[11:8];
  assign off = bus.reg_addr[7:0];
  assign wr = bus.reg_req & bus.reg_we;
  assign rd = bus.reg_req & ~bus.reg_we;
  assign ci = cnt_decode(off);
  assign hi = ~off[2];
  always_comb begin
    rd_val = '0;
    if (blk == BLK_GEN)
      rd_val = off == OFF_ID ? IP_ID : off == OFF_FLIP ? ~gen_flip : off == OFF_CTRL ? {30'd0, gen_ctrl} :
               off == OFF_IFG ? gen_ifg : off == OFF_FSIZE ? gen_fsize : '0;
    else if (blk == BLK_ANA)
      rd_val = off == OFF_ID ? IP_ID : off == OFF_FLIP ? ~ana_flip : off == OFF_CTRL ? {30'd0, ana_ctrl} :
               ci == CNT_NONE ? '0 : hi ? ctr[ci][63:32] : (sh_vld && sh_idx == ci) ? shadow : ctr[ci][31:0];
    else if (blk == BLK_MUX)
      rd_val = off == OFF_ID ? IP_ID : off == OFF_SEL ? {29'd0, sel} : '0;
  end
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      bus.reg_ack <= 1'b0;
      bus.reg_rdata <= '0;
      {gen_flip, ana_flip, gen_ifg, gen_fsize, shadow} <= '0;
      {gen_ctrl, ana_ctrl, sel, sh_vld} <= '0;
      sh_idx <= CNT_PKTS;
      wr_ptr <= '0;
      buf_mem <= '{default: '0};
    end else begin
      bus.reg_ack <= bus.reg_req;
      bus.reg_rdata <= rd ? rd_val : '0;
      if (wr && blk == BLK_GEN) begin
        if (off == OFF_FLIP) gen_flip <= bus.reg_wdata;
        if (off == OFF_CTRL) gen_ctrl <= bus.reg_wdata[1:0];
        if (off == OFF_IFG) gen_ifg <= bus.reg_wdata;
        if (off == OFF_FSIZE) begin
          gen_fsize <= bus.reg_wdata;
          wr_ptr <= '0;
        end
        if (off == OFF_DATA && wr_ptr != (AW+1)'(BUF_WORDS)) begin
          buf_mem[wr_ptr[AW-1:0]] <= bus.reg_wdata;
          wr_ptr <= wr_ptr + 1'b1;
        end
      end
      if (wr && blk == BLK_ANA && off == OFF_FLIP) ana_flip <= bus.reg_wdata;
      if (wr && blk == BLK_ANA && off == OFF_CTRL) ana_ctrl <= bus.reg_wdata[1:0];
      if (wr && blk == BLK_MUX && off == OFF_SEL) sel <= bus.reg_wdata[2:0];
      // High-word read latches the low word so a 64-bit read is coherent
      if (rd && blk == BLK_ANA && ci != CNT_NONE) begin
        sh_vld <= hi;
        if (hi) begin
          shadow <= ctr[ci][31:0];
          sh_idx <= ci;
        end
      end
    end
  end
  gen_state_e state, state_nxt;
  logic [31:0] cnt, cnt_nxt, crc, crc_nxt, crc_upd, ifg_eff, bword, fcs;
  logic [63:0] seq;
  logic [AW+1:0] bidx;
  logic [2:0] k;
  logic [7:0] tx_byte, bbyte, sbyte, fbyte, gen_txd;
  logic tx_on, seq_inc, tail, gen_en;
  assign ifg_eff = gen_ifg < 32'd12 ? 32'd12 : gen_ifg;
  assign bidx = state == GEN_FRAME ? cnt[AW+1:0] + (AW+2)'(8) : cnt[AW+1:0];
  assign bword = buf_mem[bidx[AW+1:2]];
  assign bbyte = bword[{~bidx[1:0], 3'b0} +: 8];
  assign tail = gen_ctrl[1] && (cnt + 32'd8 >= gen_fsize);
  assign k = cnt[2:0] - gen_fsize[2:0];
  assign sbyte = seq[{~k, 3'b0} +: 8];
  assign fcs = ~crc;
  assign fbyte = fcs[{cnt[1:0], 3'b0} +: 8];
  spark_crc32_byte u_gen_crc (.crc(crc), .data(tx_byte), .crc_next(crc_upd));
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) state <= GEN_IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt + 32'd1;
    crc_nxt = crc;
    tx_on = 1'b0;
    tx_byte = '0;
    seq_inc = 1'b0;
    case (state)
      GEN_IDLE: begin
        cnt_nxt = '0;
        if (gen_ctrl[0]) state_nxt = GEN_PRE;
      end
      GEN_PRE: begin
        tx_on = 1'b1;
        tx_byte = bbyte;
        crc_nxt = '1;
        if (cnt == 32'd7) begin
          cnt_nxt = '0;
          state_nxt = gen_fsize == '0 ? GEN_FCS : GEN_FRAME;
        end
      end
      GEN_FRAME: begin
        tx_on = 1'b1;
        tx_byte = tail ? sbyte : bbyte;
        crc_nxt = crc_upd;
        if (cnt + 32'd1 >= gen_fsize) begin
          cnt_nxt = '0;
          state_nxt = GEN_FCS;
        end
      end
      GEN_FCS: begin
        tx_on = 1'b1;
        tx_byte = fbyte;
        if (cnt == 32'd3) begin
          cnt_nxt = '0;
          state_nxt = GEN_GAP;
          seq_inc = 1'b1;
        end
      end
      GEN_GAP: begin
        if (cnt + 32'd1 >= ifg_eff) begin
          cnt_nxt = '0;
          state_nxt = gen_ctrl[0] ? GEN_PRE : GEN_IDLE;
        end
      end
      default: state_nxt = GEN_IDLE;
    endcase
  end
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      {cnt, crc, seq, gen_txd, gen_en} <= '0;
    end else begin
      cnt <= cnt_nxt;
      crc <= crc_nxt;
      seq <= seq + 64'(seq_inc);
      gen_txd <= tx_byte;
      gen_en <= tx_on;
    end
  end
  assign gmii0_txd = sel[0] ? gen_txd : '0;
  assign gmii0_tx_en = sel[0] & gen_en;
  assign gmii1_txd = sel[1] ? gen_txd : '0;
  assign gmii1_tx_en = sel[1] & gen_en;
  logic [7:0] rxd;
  logic rx_dv, prev_dv, armed, armed_now, in_frame, counting, rise, fall, fend, oct, bad;
  logic [31:0] a_crc, a_crc_upd, flen;
  assign rxd = sel[2] ? gmii0_rxd : gmii1_rxd;
  assign rx_dv = sel[2] ? gmii0_rx_dv : gmii1_rx_dv;
  assign counting = ana_ctrl[0] & ~ana_ctrl[1];
  assign rise = rx_dv & ~prev_dv;
  assign fall = ~rx_dv & prev_dv;
  // A frame is only counted if counting was active at its rx_dv rising edge and stayed active
  assign armed_now = rise ? counting : armed & counting;
  assign fend = fall & in_frame & armed & counting;
  assign oct = rx_dv & in_frame & armed & counting;
  assign bad = {<<{a_crc}} != CRC_RESIDUE;
  spark_crc32_byte u_ana_crc (.crc(a_crc), .data(rxd), .crc_next(a_crc_upd));
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      {prev_dv, armed, in_frame, a_crc, flen} <= '0;
      ctr <= '{default: '0};
    end else begin
      prev_dv <= rx_dv;
      armed <= armed_now;
      if (fall) in_frame <= 1'b0;
      else if (rx_dv && armed_now && !in_frame && rxd == 8'hD5) begin
        in_frame <= 1'b1;
        a_crc <= '1;
        flen <= '0;
      end else if (rx_dv && in_frame) begin
        a_crc <= a_crc_upd;
        flen <= flen + 32'd1;
      end
      ctr[CNT_PKTS] <= ctr[CNT_PKTS] + 64'(fend);
      ctr[CNT_OCTETS] <= ctr[CNT_OCTETS] + 64'(oct);
      ctr[CNT_IDLE] <= ctr[CNT_IDLE] + 64'(~rx_dv & counting);
      ctr[CNT_BAD_PKTS] <= ctr[CNT_BAD_PKTS] + 64'(fend & bad);
      ctr[CNT_BAD_OCT] <= ctr[CNT_BAD_OCT] + ((fend & bad) ? 64'(flen) : 64'd0);
    end
  end
endmodule

// File: tb/tb_spark_port_tester.sv
// tb_spark_port_tester: register vectors, loopback traffic, CRC corruption and async reset checks
`timescale 1ns/1ps
module tb_spark_port_tester;
  import spark_tester_pkg::*;
  logic aclk = 1'b0, arstn = 1'b0;
  always #5 aclk = ~aclk;
  spark_port_tester_if bus();
  logic [7:0] tx0, tx1, rx0, rx1, corrupt;
  logic en0, en1, dv0, dv1;
  assign rx1 = tx0 ^ corrupt;
  assign dv1 = en0;
  assign rx0 = 8'h00;
  assign dv0 = 1'b0;
  spark_port_tester dut (
    .aclk(aclk), .arstn(arstn), .bus(bus),
    .gmii0_txd(tx0), .gmii0_tx_en(en0), .gmii1_txd(tx1), .gmii1_tx_en(en1),
    .gmii0_rxd(rx0), .gmii0_rx_dv(dv0), .gmii1_rxd(rx1), .gmii1_rx_dv(dv1)
  );
  int n_tests = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  typedef struct {logic [31:0] exp; bit on; string nm;} sb_t;
  sb_t sb_q[$];
  task automatic xact(input bit we, input logic [11:0] a, input logic [31:0] d, input bit on,
                      input logic [31:0] exp, input string nm, output logic [31:0] rdv);
    int k;
    sb_t s;
    @(negedge aclk);
    bus.reg_req = 1'b1; bus.reg_we = we; bus.reg_addr = a; bus.reg_wdata = d;
    sb_q.push_back('{exp, on, nm});
    @(negedge aclk);
    bus.reg_req = 1'b0;
    k = 0;
    while (!bus.reg_ack && k < 4) begin
      @(negedge aclk);
      k++;
    end
    s = sb_q.pop_front();
    rdv = bus.reg_rdata;
    chk({s.nm, " ack latency"}, 64'(k), 0);
    if (s.on) chk(s.nm, rdv, s.exp);
  endtask
  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic [31:0] r;
    xact(1'b1, a, d, 1'b0, '0, "write", r);
  endtask
  task automatic rdc(input logic [11:0] a, input logic [31:0] exp, input string nm);
    logic [31:0] r;
    xact(1'b0, a, '0, 1'b1, exp, nm, r);
  endtask
  task automatic rd64(input logic [11:0] a, output logic [63:0] v);
    logic [31:0] h, l;
    xact(1'b0, a, '0, 1'b0, '0, "rd hi", h);
    xact(1'b0, a + 12'h4, '0, 1'b0, '0, "rd lo", l);
    v = {h, l};
  endtask
  task automatic wait_en(input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge aclk);
      ok = en0;
    end
    chk(nm, 64'(ok), 1);
  endtask
  function automatic logic [31:0] crc_ref(input logic [7:0] q[$], input int lo, input int n);
    logic [31:0] c = '1;
    for (int i = lo; i < lo + n; i++) begin
      c ^= {24'd0, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    return ~c;
  endfunction
  int nfr = 0, gap = 0, gap1 = -1;
  logic pen = 1'b0;
  logic [7:0] fr0[$], fr1[$];
  always @(negedge aclk) begin
    if (en0) begin
      if (nfr == 0) fr0.push_back(tx0);
      else if (nfr == 1) fr1.push_back(tx0);
      if (!pen && nfr == 1) gap1 = gap;
      gap = 0;
    end else begin
      if (pen) nfr++;
      gap++;
    end
    pen = en0;
  end
  typedef struct {bit we; logic [11:0] a; logic [31:0] d; logic [31:0] exp; string nm;} vec_t;
  vec_t vt[$];
  initial begin
    logic [63:0] p, v, i1, i2;
    logic [31:0] r;
    logic [7:0] ex[$];
    logic [31:0] fc;
    int mis;
    bus.reg_req = 1'b0; bus.reg_we = 1'b0; bus.reg_addr = '0; bus.reg_wdata = '0;
    corrupt = 8'h00;
    vt.push_back('{0, 12'h000, 0, IP_ID, "id gen"});
    vt.push_back('{0, 12'h100, 0, IP_ID, "id ana"});
    vt.push_back('{0, 12'h200, 0, IP_ID, "id mux"});
    vt.push_back('{1, 12'h10C, 32'h12345678, 0, "wr flip"});
    vt.push_back('{0, 12'h10C, 0, 32'hEDCBA987, "flip ana"});
    vt.push_back('{0, 12'h00C, 0, 32'hFFFFFFFF, "flip gen reset"});
    vt.push_back('{0, 12'h120, 0, 0, "pkts hi"});
    vt.push_back('{0, 12'h124, 0, 0, "pkts lo"});
    vt.push_back('{0, 12'h128, 0, 0, "octets hi"});
    vt.push_back('{0, 12'h12C, 0, 0, "octets lo"});
    vt.push_back('{0, 12'h130, 0, 0, "idle hi"});
    vt.push_back('{0, 12'h134, 0, 0, "idle lo"});
    vt.push_back('{0, 12'h158, 0, 0, "bad pkts hi"});
    vt.push_back('{0, 12'h15C, 0, 0, "bad pkts lo"});
    vt.push_back('{0, 12'h160, 0, 0, "bad oct hi"});
    vt.push_back('{0, 12'h164, 0, 0, "bad oct lo"});
    vt.push_back('{0, 12'h208, 0, 0, "sel reset"});
    vt.push_back('{0, 12'h300, 0, 0, "unmapped block"});
    vt.push_back('{1, 12'h0FC, 32'hDEAD, 0, "wr unmapped"});
    vt.push_back('{0, 12'h0FC, 0, 0, "unmapped offset"});
    vt.push_back('{0, 12'h050, 0, 0, "data write-only"});
    repeat (3) @(negedge aclk);
    arstn = 1'b1;
    foreach (vt[i]) xact(vt[i].we, vt[i].a, vt[i].d, !vt[i].we, vt[i].exp, vt[i].nm, r);
    wr(12'h208, 3);
    rdc(12'h208, 3, "sel readback");
    wr(12'h044, 50);
    wr(12'h014, 5);
    wr(12'h050, 32'h55555555);
    wr(12'h050, 32'h555555D5);
    for (int j = 0; j < 14; j++)
      wr(12'h050, {8'(4*j+1), 8'(4*j+2), 8'(4*j+3), 8'(4*j+4)});
    wr(12'h110, 1);
    wr(12'h010, 3);
    wait_en("gen start");
    chk("port1 tx mirrors gen", 64'(en1), 1);
    repeat (1000) @(negedge aclk);
    wr(12'h010, 0);
    repeat (100) @(negedge aclk);
    wr(12'h110, 3);
    rd64(12'h120, p);
    chk("pkts>=2", 64'(p >= 2), 1);
    rd64(12'h158, v);
    chk("bad pkts after run", v, 0);
    rd64(12'h128, v);
    chk("octets=54*pkts", v, 54 * p);
    rd64(12'h130, i1);
    repeat (500) @(negedge aclk);
    rd64(12'h120, v);
    chk("pkts frozen", v, p);
    rd64(12'h130, i2);
    chk("idle frozen", i2, i1);
    for (int j = 0; j < 7; j++) ex.push_back(8'h55);
    ex.push_back(8'hD5);
    for (int j = 0; j < 42; j++) ex.push_back(8'(j + 1));
    for (int j = 0; j < 8; j++) ex.push_back(8'h00);
    fc = crc_ref(ex, 8, 50);
    for (int j = 0; j < 4; j++) ex.push_back(fc[8*j +: 8]);
    chk("frame0 length", 64'(fr0.size()), 62);
    mis = 0;
    for (int j = 0; j < 62 && j < fr0.size(); j++) if (fr0[j] !== ex[j]) mis++;
    chk("frame0 bytes", 64'(mis), 0);
    chk("frame1 length", 64'(fr1.size()), 62);
    v = '0;
    if (fr1.size() >= 58) for (int j = 50; j < 58; j++) v = {v[55:0], fr1[j]};
    chk("frame1 seq", v, 1);
    chk("ifg min 12", 64'(gap1), 12);
    wr(12'h208, 1);
    wr(12'h110, 1);
    wr(12'h010, 1);
    wait_en("gen start 2");
    chk("port1 tx idle", 64'(en1), 0);
    repeat (20) @(negedge aclk);
    corrupt = 8'h01;
    @(negedge aclk);
    corrupt = 8'h00;
    wr(12'h010, 0);
    repeat (100) @(negedge aclk);
    rd64(12'h158, v);
    chk("bad pkts", v, 1);
    rd64(12'h160, v);
    chk("bad octets", v, 54);
    rd64(12'h120, v);
    chk("pkts after bad", v, p + 1);
    wr(12'h208, 3);
    wr(12'h010, 1);
    wait_en("gen start 3");
    repeat (10) @(negedge aclk);
    arstn = 1'b0;
    #1;
    chk("async tx_en0 drop", 64'(en0), 0);
    chk("async tx_en1 drop", 64'(en1), 0);
    @(negedge aclk);
    arstn = 1'b1;
    rdc(12'h010, 0, "gen ctrl after reset");
    rdc(12'h044, 0, "fsize after reset");
    rdc(12'h110, 0, "ana ctrl after reset");
    rdc(12'h208, 0, "sel after reset");
    rdc(12'h00C, 32'hFFFFFFFF, "flip after reset");
    rd64(12'h120, v);
    chk("pkts after reset", v, 0);
    rd64(12'h158, v);
    chk("bad pkts after reset", v, 0);
    rd64(12'h160, v);
    chk("bad octets after reset", v, 0);
    repeat (20) @(negedge aclk);
    chk("tx idle after reset", 64'(en0), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
